// File: rtl/mac_pkg.sv
// mac_pkg: types and default widths shared by the MAC sequencing controller
// and the MAC unit it feeds.
//   - mac_seq_state_e : controller FSM state encoding (also exported on the
//                       controller's dbg_state port)
//   - MAC_*           : default parameter values for both sides of the link
`timescale 1ns/1ps
package mac_pkg;

  localparam int MAC_MULER_WIDTH   = 8;   // operand width per MAC input
  localparam int MAC_NUM_WIDTH     = 8;   // dot-product length field width
  localparam int MAC_OUTPUT_WIDTH  = 32;  // accumulator / result width
  localparam int MAC_DRAIN_TIMEOUT = 16;  // max cycles spent waiting in DRAIN

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_CAPTURE = 2'd3
  } mac_seq_state_e;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if: job-side bus of the MAC sequencing controller.
//   cmd_*  : job command (cmd_len = operand-pair count K)
//   op_*   : operand-pair stream
//   res_*  : completed dot-product result
// Modports: master = job source / result sink, slave = controller.
//
// Handshake rule for all three channels: a transfer happens on a rising clk
// edge where valid and ready are both 1. A source that has raised valid keeps
// valid and its payload stable until that transfer; ready may depend
// combinationally on valid, valid never depends on ready.
`timescale 1ns/1ps
interface mac_seq_ctrl_if #(
  parameter int MULER_WIDTH  = 8,
  parameter int NUM_WIDTH    = 8,
  parameter int OUTPUT_WIDTH = 32
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [NUM_WIDTH-1:0]    cmd_len;

  logic                    op_valid;
  logic                    op_ready;
  logic [MULER_WIDTH-1:0]  op_a;
  logic [MULER_WIDTH-1:0]  op_b;

  logic                    res_valid;
  logic                    res_ready;
  logic [OUTPUT_WIDTH-1:0] res_data;

  modport master (
    output cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready,
    input  cmd_ready, op_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready,
    output cmd_ready, op_ready, res_valid, res_data
  );

endinterface

// File: rtl/mac_seq_result_slot.sv
// mac_seq_result_slot: one-entry valid/ready holding register for results.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_data and mark the slot full
//   load_data  : value to capture
//   take       : consumer ready; empties a full slot
//   valid      : slot full (data is presentable)
//   data       : held value, stable while valid=1
`timescale 1ns/1ps
module mac_seq_result_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             take,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      // The controller only loads an empty slot; load still wins so a result
      // can never be lost.
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && take) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one dot-product job at a time into a MAC unit.
// A command of length K opens a job; K operand pairs are streamed straight
// through to the MAC (mac_data), the first one flagged with mac_num_valid and
// mac_num=K. The controller then waits for the MAC completion strobe, captures
// mac_result into a one-entry result slot and presents it on res_*.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : cmd_*, op_*, res_* handshakes
//   mac_num_valid     : job-start strobe (same cycle as the first pair)
//   mac_num           : job length K
//   mac_data          : [0]=op_a, [1]=op_b, combinational pass-through
//   mac_data_ready    : MAC completion strobe
//   mac_result        : MAC registered result
//   err_underrun      : pulse, operand stream broke after the first pair
//   err_timeout       : pulse, MAC did not complete within DRAIN_TIMEOUT
//   err_zero_len      : pulse, command with length 0 rejected
//   dbg_state         : current FSM state
// Optional feature (macro MAC_SEQ_CTRL_PERF_EN): saturating perf_jobs
// (completed jobs) and perf_errs (sum of error pulses) outputs.
`timescale 1ns/1ps
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int MULER_WIDTH   = MAC_MULER_WIDTH,
  parameter int NUM_WIDTH     = MAC_NUM_WIDTH,
  parameter int OUTPUT_WIDTH  = MAC_OUTPUT_WIDTH,
  parameter int DRAIN_TIMEOUT = MAC_DRAIN_TIMEOUT
) (
  input  logic                              clk,
  input  logic                              rst,
  mac_seq_ctrl_if.slave                     bus,
  output logic                              mac_num_valid,
  output logic [NUM_WIDTH-1:0]              mac_num,
  output logic [1:0][MULER_WIDTH-1:0]       mac_data,
  input  logic                              mac_data_ready,
  input  logic [OUTPUT_WIDTH-1:0]           mac_result,
  output logic                              err_underrun,
  output logic                              err_timeout,
  output logic                              err_zero_len,
`ifdef MAC_SEQ_CTRL_PERF_EN
  output logic [31:0]                       perf_jobs,
  output logic [15:0]                       perf_errs,
`endif
  output mac_seq_state_e                    dbg_state
);

  localparam int WAIT_W = $clog2(DRAIN_TIMEOUT + 1);

  mac_seq_state_e        state, state_nxt;
  logic [NUM_WIDTH-1:0]  remaining, remaining_nxt;
  logic [NUM_WIDTH-1:0]  mac_num_nxt;
  logic [WAIT_W-1:0]     wait_cnt, wait_nxt;
  logic                  started, started_nxt;   // first pair of the job taken
  logic                  underrun_nxt, timeout_nxt, zero_nxt;
  logic                  slot_load;
  logic                  slot_valid;
  logic [OUTPUT_WIDTH-1:0] slot_data;
  logic                  cmd_fire, op_fire;

  // A full slot does not block a new command if it is being emptied in the
  // same cycle.
  assign bus.cmd_ready = (state == ST_IDLE) && (!slot_valid || bus.res_ready);
  assign bus.op_ready  = (state == ST_STREAM);
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  assign op_fire       = bus.op_valid && bus.op_ready;

  assign mac_data[0]   = bus.op_a;
  assign mac_data[1]   = bus.op_b;
  assign mac_num_valid = op_fire && !started;

  assign bus.res_valid = slot_valid;
  assign bus.res_data  = slot_data;
  assign dbg_state     = state;

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    mac_num_nxt   = mac_num;
    wait_nxt      = wait_cnt;
    started_nxt   = started;
    underrun_nxt  = 1'b0;
    timeout_nxt   = 1'b0;
    zero_nxt      = 1'b0;
    slot_load     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (bus.cmd_len == '0) begin
            zero_nxt = 1'b1;
          end else begin
            remaining_nxt = bus.cmd_len;
            mac_num_nxt   = bus.cmd_len;
            started_nxt   = 1'b0;
            state_nxt     = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (op_fire) begin
          started_nxt   = 1'b1;
          remaining_nxt = remaining - NUM_WIDTH'(1);
          if (remaining == NUM_WIDTH'(1)) begin
            wait_nxt  = '0;
            state_nxt = ST_DRAIN;
          end
        end else if (started) begin
          // Gaps are only tolerated before the MAC has been started.
          underrun_nxt  = 1'b1;
          remaining_nxt = '0;
          started_nxt   = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (mac_data_ready) begin
          wait_nxt  = '0;
          state_nxt = ST_CAPTURE;
        end else if (wait_cnt == WAIT_W'(DRAIN_TIMEOUT)) begin
          timeout_nxt = 1'b1;
          wait_nxt    = '0;
          state_nxt   = ST_IDLE;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ST_CAPTURE: begin
        slot_load   = 1'b1;
        started_nxt = 1'b0;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      mac_num      <= '0;
      wait_cnt     <= '0;
      started      <= 1'b0;
      err_underrun <= 1'b0;
      err_timeout  <= 1'b0;
      err_zero_len <= 1'b0;
    end else begin
      state        <= state_nxt;
      remaining    <= remaining_nxt;
      mac_num      <= mac_num_nxt;
      wait_cnt     <= wait_nxt;
      started      <= started_nxt;
      err_underrun <= underrun_nxt;
      err_timeout  <= timeout_nxt;
      err_zero_len <= zero_nxt;
    end
  end

  mac_seq_result_slot #(
    .WIDTH (OUTPUT_WIDTH)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (slot_load),
    .load_data (mac_result),
    .take      (bus.res_ready),
    .valid     (slot_valid),
    .data      (slot_data)
  );

`ifdef MAC_SEQ_CTRL_PERF_EN
  // Errors are counted from the registered pulses, so each pulse is counted
  // exactly once in the cycle it is visible.
  logic [1:0]  err_sum;
  logic [16:0] errs_wide;
  assign err_sum   = 2'({1'b0, err_underrun}) + 2'({1'b0, err_timeout})
                   + 2'({1'b0, err_zero_len});
  assign errs_wide = {1'b0, perf_errs} + 17'(err_sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_jobs <= '0;
      perf_errs <= '0;
    end else begin
      if (slot_load && (perf_jobs != '1)) perf_jobs <= perf_jobs + 32'd1;
      perf_errs <= errs_wide[16] ? '1 : errs_wide[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
`timescale 1ns/1ps
module tb_mac_seq_ctrl;
  import mac_pkg::*;

  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.MULER_WIDTH(8), .NUM_WIDTH(8), .OUTPUT_WIDTH(32)) bus ();

  logic            mac_num_valid;
  logic [7:0]      mac_num;
  logic [1:0][7:0] mac_data;
  logic            mac_data_ready;
  logic [31:0]     mac_result;
  logic            err_underrun, err_timeout, err_zero_len;
  mac_seq_state_e  dbg_state;
`ifdef MAC_SEQ_CTRL_PERF_EN
  logic [31:0]     perf_jobs;
  logic [15:0]     perf_errs;
`endif

  mac_seq_ctrl #(
    .MULER_WIDTH(8), .NUM_WIDTH(8), .OUTPUT_WIDTH(32), .DRAIN_TIMEOUT(TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .mac_num_valid  (mac_num_valid),
    .mac_num        (mac_num),
    .mac_data       (mac_data),
    .mac_data_ready (mac_data_ready),
    .mac_result     (mac_result),
    .err_underrun   (err_underrun),
    .err_timeout    (err_timeout),
    .err_zero_len   (err_zero_len),
`ifdef MAC_SEQ_CTRL_PERF_EN
    .perf_jobs      (perf_jobs),
    .perf_errs      (perf_errs),
`endif
    .dbg_state      (dbg_state)
  );

  // ---------------- MAC unit model (delay 1) ----------------
  logic        model_en;
  logic        model_ready, force_ready;
  logic [31:0] model_result, force_result;
  assign mac_data_ready = model_ready | force_ready;
  assign mac_result     = force_ready ? force_result : model_result;

  always begin : mac_model
    logic       s_rst, s_nv, s_fire;
    logic [7:0] s_num, s_a, s_b, m_num, m_cnt;
    logic [31:0] m_acc;
    @(negedge clk);
    s_rst  = rst;
    s_nv   = mac_num_valid;
    s_num  = mac_num;
    s_fire = bus.op_valid && bus.op_ready;
    s_a    = mac_data[0];
    s_b    = mac_data[1];
    @(posedge clk); #1;
    model_ready = 1'b0;
    if (s_rst) begin
      m_num = 0; m_cnt = 0; m_acc = 0;
    end else begin
      if (s_nv) begin
        m_num = s_num; m_cnt = 0; m_acc = 0;
      end
      if (s_fire) begin
        m_acc = m_acc + 32'(s_a) * 32'(s_b);
        m_cnt = m_cnt + 8'd1;
        if (m_cnt == m_num && model_en) begin
          model_ready  = 1'b1;
          model_result = m_acc;
        end
      end
    end
  end

  int nv_count;
  always @(negedge clk) if (mac_num_valid) nv_count++;

  // ---------------- scoreboard ----------------
  int n_tests;
  int n_fail;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus table ----------------
  typedef struct packed {
    logic [7:0]      len;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [31:0]     exp_res;
    logic [3:0]      exp_lat;
  } job_t;

  function automatic job_t mk_job(input logic [7:0] len,
                                  input logic [3:0][7:0] a,
                                  input logic [3:0][7:0] b,
                                  input logic [31:0] exp_res);
    job_t j;
    j.len = len; j.a = a; j.b = b; j.exp_res = exp_res; j.exp_lat = 4'd3;
    return j;
  endfunction

  job_t jobs [5];

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [7:0] len);
    logic seen;
    seen = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = len;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("cmd_accept", 64'(seen), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_pairs(input job_t j);
    for (int i = 0; i < int'(j.len); i++) begin
      bus.op_valid = 1'b1;
      bus.op_a     = j.a[i];
      bus.op_b     = j.b[i];
      @(negedge clk);
      check("op_ready", 64'(bus.op_ready), 64'd1);
      check("mac_num_valid", 64'(mac_num_valid), 64'(i == 0));
      if (i == 0) check("mac_num", 64'(mac_num), 64'(j.len));
      check("mac_data", 64'({mac_data[1], mac_data[0]}), 64'({j.b[i], j.a[i]}));
      tick();
    end
    bus.op_valid = 1'b0;
  endtask

  // Called in the cycle after the last pair; latency counts from that pair.
  task automatic wait_result(input logic [3:0] exp_lat);
    logic        seen;
    int          lat;
    logic [31:0] exp;
    seen = 1'b0;
    lat  = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    check("res_valid_seen", 64'(seen), 64'd1);
    check("res_latency", 64'(lat), 64'(exp_lat));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("res_data", 64'(bus.res_data), 64'(exp));
    tick();
  endtask

  task automatic release_result();
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("res_hold", 64'(bus.res_valid), 64'd1);
    check("cmd_ready_drain", 64'(bus.cmd_ready), 64'd1);
    tick();
    bus.res_ready = 1'b0;
    @(negedge clk);
    check("res_cleared", 64'(bus.res_valid), 64'd0);
    tick();
  endtask

  // ---------------- test sequence ----------------
  int   nv0, idx;
  logic seen_to;
  job_t jtmp;

  initial begin
    n_tests = 0; n_fail = 0; nv_count = 0;
    model_en = 1'b1; model_ready = 1'b0; model_result = '0;
    force_ready = 1'b0; force_result = '0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_len = '0;
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.res_ready = 1'b0;

    jobs[0] = mk_job(8'd3, {8'd0, 8'd5, 8'd3, 8'd1}, {8'd0, 8'd6, 8'd4, 8'd2}, 32'd44);
    jobs[1] = mk_job(8'd1, {8'd0, 8'd0, 8'd0, 8'd7}, {8'd0, 8'd0, 8'd0, 8'd7}, 32'd49);
    jobs[2] = mk_job(8'd4, {8'd2, 8'd0, 8'd1, 8'd255}, {8'd3, 8'd9, 8'd1, 8'd255}, 32'd65032);
    jobs[3] = mk_job(8'd2, {8'd0, 8'd0, 8'd30, 8'd10}, {8'd0, 8'd0, 8'd40, 8'd20}, 32'd1400);
    jobs[4] = mk_job(8'd4, {8'd8, 8'd8, 8'd8, 8'd8}, {8'd8, 8'd8, 8'd8, 8'd8}, 32'd256);

    // Reset state
    tick(); tick();
    @(negedge clk);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_data", 64'(bus.res_data), 64'd0);
    check("rst_mac_num", 64'(mac_num), 64'd0);
    check("rst_errs", 64'({err_underrun, err_timeout, err_zero_len}), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("idle_op_ready", 64'(bus.op_ready), 64'd0);
    tick();

    // Table-driven gapless jobs
    for (int v = 0; v < 5; v++) begin
      exp_q.push_back(jobs[v].exp_res);
      send_cmd(jobs[v].len);
      send_pairs(jobs[v]);
      wait_result(jobs[v].exp_lat);
      release_result();
    end

    // Underrun after two of four pairs; waiting before the first pair is legal
    send_cmd(8'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("prestart_wait_state", 64'(dbg_state), 64'(ST_STREAM));
      check("prestart_no_underrun", 64'(err_underrun), 64'd0);
      tick();
    end
    bus.op_valid = 1'b1; bus.op_a = 8'd1; bus.op_b = 8'd1;
    tick();
    bus.op_a = 8'd2; bus.op_b = 8'd2;
    tick();
    bus.op_valid = 1'b0;
    @(negedge clk);
    check("underrun_not_yet", 64'(err_underrun), 64'd0);
    tick();
    @(negedge clk);
    check("underrun_pulse", 64'(err_underrun), 64'd1);
    check("underrun_idle", 64'(dbg_state), 64'(ST_IDLE));
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("underrun_single", 64'(err_underrun), 64'd0);
      check("underrun_no_res", 64'(bus.res_valid), 64'd0);
      tick();
    end
    exp_q.push_back(jobs[1].exp_res);
    send_cmd(jobs[1].len);
    send_pairs(jobs[1]);
    wait_result(jobs[1].exp_lat);
    release_result();

    // Zero-length command
    nv0 = nv_count;
    bus.cmd_valid = 1'b1; bus.cmd_len = 8'd0;
    @(negedge clk);
    check("zero_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("zero_pulse", 64'(err_zero_len), 64'd1);
    check("zero_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("zero_cmd_ready_after", 64'(bus.cmd_ready), 64'd1);
    tick();
    @(negedge clk);
    check("zero_single", 64'(err_zero_len), 64'd0);
    tick();
    check("zero_no_mac_start", 64'(nv_count - nv0), 64'd0);

    // Drain timeout: MAC never completes
    model_en = 1'b0;
    jtmp = mk_job(8'd1, {8'd0, 8'd0, 8'd0, 8'd1}, {8'd0, 8'd0, 8'd0, 8'd1}, 32'd1);
    send_cmd(jtmp.len);
    send_pairs(jtmp);
    idx = 0; seen_to = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (err_timeout) begin
        seen_to = 1'b1;
        break;
      end
      tick();
      idx++;
    end
    check("timeout_seen", 64'(seen_to), 64'd1);
    check("timeout_cycles", 64'(idx), 64'(TO + 1));
    check("timeout_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("timeout_no_res", 64'(bus.res_valid), 64'd0);
    tick();
    @(negedge clk);
    check("timeout_single", 64'(err_timeout), 64'd0);
    tick();
    model_en = 1'b1;

    // Result backpressure with a second command pending
    exp_q.push_back(jobs[3].exp_res);
    send_cmd(jobs[3].len);
    send_pairs(jobs[3]);
    wait_result(jobs[3].exp_lat);
    bus.cmd_valid = 1'b1; bus.cmd_len = 8'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_res_valid", 64'(bus.res_valid), 64'd1);
      check("bp_res_data", 64'(bus.res_data), 64'd1400);
      check("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      tick();
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("bp_cmd_ready_rise", 64'(bus.cmd_ready), 64'd1);
    tick();
    bus.cmd_valid = 1'b0; bus.res_ready = 1'b0;
    @(negedge clk);
    check("bp_second_stream", 64'(dbg_state), 64'(ST_STREAM));
    check("bp_res_taken", 64'(bus.res_valid), 64'd0);
    tick();
    jtmp = mk_job(8'd1, {8'd0, 8'd0, 8'd0, 8'd2}, {8'd0, 8'd0, 8'd0, 8'd3}, 32'd6);
    exp_q.push_back(jtmp.exp_res);
    send_pairs(jtmp);
    wait_result(jtmp.exp_lat);
    release_result();

    // Reset mid-stream, then a stale completion strobe
    send_cmd(8'd5);
    bus.op_valid = 1'b1; bus.op_a = 8'd1; bus.op_b = 8'd1;
    tick();
    bus.op_a = 8'd2; bus.op_b = 8'd2;
    tick();
    bus.op_valid = 1'b0; bus.op_a = 8'd0; bus.op_b = 8'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("mrst_res_valid", 64'(bus.res_valid), 64'd0);
    check("mrst_res_data", 64'(bus.res_data), 64'd0);
    check("mrst_mac_num_valid", 64'(mac_num_valid), 64'd0);
    check("mrst_mac_num", 64'(mac_num), 64'd0);
    check("mrst_errs", 64'({err_underrun, err_timeout, err_zero_len}), 64'd0);
    check("mrst_op_ready", 64'(bus.op_ready), 64'd0);
    tick();
    force_result = 32'd123; force_ready = 1'b1;
    tick();
    force_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stale_no_res", 64'(bus.res_valid), 64'd0);
      check("stale_idle", 64'(dbg_state), 64'(ST_IDLE));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameter MULER_WIDTH, default 8, operand width per MAC input.
REQ-002 Parameter NUM_WIDTH, default 8, width of the dot-product length field.
REQ-003 Parameter OUTPUT_WIDTH, default 32, MAC accumulator and result width.
REQ-004 Parameter DRAIN_TIMEOUT, default 16, maximum cycles DRAIN waits for mac_data_ready.
REQ-005 Port clk, input, 1: single clock, all logic on posedge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port cmd_valid / cmd_ready, in / out, 1 each: job command handshake.
REQ-008 Port cmd_len, input, NUM_WIDTH: operand-pair count K of the job.
REQ-009 Port op_valid / op_ready, in / out, 1 each: operand-pair handshake.
REQ-010 Port op_a / op_b, input, MULER_WIDTH each: operand pair.
REQ-011 Port mac_num_valid, output, 1: job-start strobe to the MAC unit.
REQ-012 Port mac_num, output, NUM_WIDTH: length K to the MAC unit.
REQ-013 Port mac_data, output, [1:0][MULER_WIDTH]: [0]=op_a, [1]=op_b.
REQ-014 Port mac_data_ready / mac_result, input, 1 / OUTPUT_WIDTH: MAC completion strobe and registered result.
REQ-015 Port res_valid / res_ready / res_data, out / in / out, 1 / 1 / OUTPUT_WIDTH: result handshake.
REQ-016 Port err_underrun / err_timeout / err_zero_len, output, 1 each: single-cycle error pulses.

Function
REQ-017 FSM SHALL have states IDLE, STREAM, DRAIN, CAPTURE.
REQ-018 cmd_ready SHALL be 1 only in IDLE with result slot empty, or with slot full and res_ready=1 in the same cycle.
REQ-019 Command with cmd_len=0 SHALL pulse err_zero_len next cycle, generate no MAC traffic, and stay in IDLE.
REQ-020 Command with K>0 SHALL latch K into a remaining counter and move to STREAM.
REQ-021 op_ready SHALL be 1 only in STREAM; mac_data SHALL equal {op_b, op_a} combinationally.
REQ-022 First accepted pair SHALL assert mac_num_valid for exactly that cycle with mac_num=K.
REQ-023 Each accepted pair SHALL decrement remaining; acceptance with remaining=1 SHALL move to DRAIN.
REQ-024 Once the first pair is accepted, op_valid=0 in STREAM SHALL pulse err_underrun, discard the job, and return to IDLE; before the first pair, idle waiting is legal.
REQ-025 In DRAIN, mac_data_ready=1 SHALL move to CAPTURE; a wait counter exceeding DRAIN_TIMEOUT cycles SHALL pulse err_timeout and return to IDLE.
REQ-026 CAPTURE SHALL load res_data from mac_result, set res_valid, and return to IDLE (one cycle).
REQ-027 res_valid SHALL hold until res_ready=1; res_data SHALL stay stable while res_valid=1.
REQ-028 Minimum latency: last pair accepted at cycle t, MAC strobe at t+1 gives res_valid at t+3.
REQ-029 mac_num_valid SHALL never assert outside STREAM.

Reset
REQ-030 rst SHALL force IDLE and clear remaining and wait counters.
REQ-031 rst SHALL zero res_valid, res_data, mac_num_valid, mac_num, all err_* outputs, and the slot-full flag.
REQ-032 rst mid-STREAM or mid-DRAIN SHALL drop the job; mac_data_ready seen afterward in IDLE SHALL be ignored.

Configuration
REQ-033 Macro MAC_SEQ_CTRL_PERF_EN, if defined, SHALL add outputs perf_jobs (32 bits, completed jobs) and perf_errs (16 bits, sum of all error pulses), both saturating and reset to 0.
REQ-034 Without MAC_SEQ_CTRL_PERF_EN, the perf ports and counters SHALL be absent and behaviour otherwise identical.

Structure
REQ-035 Package mac_pkg SHALL hold the FSM state enum and default width constants shared with the MAC unit.
REQ-036 One sub-module, mac_seq_result_slot, SHALL implement the one-entry valid/ready result holding register.

Verification
REQ-037 K=3, pairs (1,2),(3,4),(5,6) gapless, mac model delay 1 -> one mac_num_valid with mac_num=3, res_data=44, res_valid at t+3.
REQ-038 K=4, op_valid drops after 2 pairs -> err_underrun single pulse, no res_valid, next K=1 job (7,7) -> res_data=49.
REQ-039 cmd_len=0 -> err_zero_len pulse, mac_num_valid never asserted, cmd_ready stays high.
REQ-040 Model never asserts mac_data_ready -> err_timeout DRAIN_TIMEOUT+1 cycles after DRAIN entry, FSM in IDLE.
REQ-041 res_ready held 0 for 10 cycles after a result -> res_data stable, cmd_ready=0 throughout, second command accepted in the cycle res_ready rises.
REQ-042 rst asserted mid-STREAM (K=5, 2 pairs sent) -> all outputs zero next cycle, later stale mac_data_ready produces no res_valid.
